// File: rtl/program_loader_host.sv
// rtl/program_loader_host.sv - host-side image loader and CPU start/run supervisor
// Streams bytes into memory, releases the CPU, handshakes start/done and supervises the run.
module program_loader_host #(
  parameter int ADDR_W       = 12,
  parameter int BASE_ADDR    = 0,
  parameter int START_CYC    = 2,
  parameter int DONE_TIMEOUT = 64,
  parameter int RUN_LIMIT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              cpu_done,
  output logic              cpu_start,
  output logic              cpu_rst,
  input  logic              abort,
  input  logic              err_clr,
  output logic              busy,
  output logic              run,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_START_HI,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP  = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [31:0]       cnt, cnt_nxt;
  logic              seen_low, seen_low_nxt;
  logic              wr_nxt;
  logic              accept;
  logic              left_idle;

  assign accept    = ld_valid & ld_ready;
  // The CPU has acknowledged start once done has been seen low in START_HI.
  assign left_idle = seen_low | ~cpu_done;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt + 32'd1;
    seen_low_nxt = seen_low;
    wr_nxt       = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          wr_nxt  = 1'b1;
          ptr_nxt = ptr + 1'b1;
          if (ld_last)          state_nxt = S_RELEASE;
          else if (ptr == TOP)  state_nxt = S_ERROR;
          else                  state_nxt = S_LOAD;
        end
      end
      S_RELEASE: begin
        if (cpu_done)                               state_nxt = S_START_HI;
        else if (cnt == 32'(DONE_TIMEOUT - 1))      state_nxt = S_ERROR;
      end
      S_START_HI: begin
        if (!cpu_done) seen_low_nxt = 1'b1;
        if (cnt >= 32'(START_CYC - 1) && left_idle) state_nxt = S_RUN;
        else if (!left_idle && cnt == 32'(DONE_TIMEOUT - 1)) state_nxt = S_ERROR;
      end
      S_RUN: begin
        if (abort)                                  state_nxt = S_IDLE;
        else if (cpu_done)                          state_nxt = S_IDLE;
        else if (RUN_LIMIT != 0 && cnt == 32'(RUN_LIMIT - 1)) state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (err_clr) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Per-state counters restart on every transition.
    if (state_nxt != state) begin
      cnt_nxt      = 32'd0;
      seen_low_nxt = 1'b0;
    end
    if (state_nxt == S_IDLE) ptr_nxt = BASE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= BASE;
      cnt      <= 32'd0;
      seen_low <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      seen_low <= seen_low_nxt;
    end
  end

  // Outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 8'd0;
      cpu_start <= 1'b0;
      cpu_rst   <= 1'b1;
      run       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ld_ready  <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
      mem_we    <= wr_nxt;
      if (wr_nxt) begin
        mem_addr  <= ptr;
        mem_wdata <= ld_data;
      end
      cpu_start <= (state_nxt == S_START_HI);
      cpu_rst   <= !((state_nxt == S_RELEASE) || (state_nxt == S_START_HI) || (state_nxt == S_RUN));
      run       <= (state_nxt == S_RUN);
      err       <= (state_nxt == S_ERROR);
      busy      <= !((state_nxt == S_IDLE) || (state_nxt == S_ERROR));
    end
  end

endmodule

// File: doc/program_loader_host.md
Name: program_loader_host

Overview:
- Host-side sequencer for the multicycle CPU, driving the far end of the controller's start/done handshake.
- Streams a program image byte-by-byte into unified instruction/data memory through the memory write port.
- Holds the CPU in reset during the load, then releases it, waits for done, and drives the start pulse (start high, then low) that launches execution.
- Supervises the run with an optional cycle limit and abort, and reports errors.

Parameters:
ADDR_W, 12, memory address width
BASE_ADDR, 0, first address written by a load
START_CYC, 2, minimum cycles cpu_start held high (>=1)
DONE_TIMEOUT, 64, max cycles to wait for each cpu_done edge before error
RUN_LIMIT, 0, run-phase cycle cap; 0 = unlimited

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
ld_valid  in  1  load byte valid
ld_data  in  8  load byte
ld_last  in  1  marks final byte of image, qualified by ld_valid
ld_ready  out  1  loader accepts byte this cycle
mem_addr  out  ADDR_W  memory write address
mem_wdata  out  8  memory write data
mem_we  out  1  memory write enable
cpu_done  in  1  CPU controller done (high only in its IDLE)
cpu_start  out  1  CPU controller start
cpu_rst  out  1  CPU reset, active-high
abort  in  1  stop a running program
err_clr  in  1  leave ERROR state
busy  out  1  high in any state except IDLE and ERROR
run  out  1  high in RUN
err  out  1  high in ERROR

Behaviour:
- Reset values while rst=0: state IDLE; ld_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_start=0, cpu_rst=1, run=0, err=0, busy=0, all counters 0. Reset mid-load or mid-run aborts immediately; partial memory contents are left as written.
- All outputs are registered.
- IDLE:
  - cpu_rst=1, ld_ready=1.
  - An accepted byte (ld_valid & ld_ready) writes and enters LOAD.
  - If that byte has ld_last=1, go directly to RELEASE.
- LOAD:
  - ld_ready=1.
  - Each accepted byte produces mem_we=1 with mem_wdata=byte and mem_addr=current pointer on the following cycle. The pointer then increments.
  - The first byte goes to BASE_ADDR.
  - Throughput is one byte per cycle; ld_valid gaps are allowed.
  - An accepted byte with ld_last=1 is written, then state goes to RELEASE and ld_ready drops the next cycle.
  - A byte accepted while the pointer equals 2^ADDR_W-1 and ld_last=0 is written, then state goes to ERROR. No wrap-around write ever occurs.
- RELEASE:
  - cpu_rst=0, ld_ready=0.
  - Wait for cpu_done=1, then go to START_HI.
  - If DONE_TIMEOUT cycles elapse without cpu_done=1, go to ERROR.
- START_HI:
  - cpu_start=1.
  - Exit when both conditions hold: at least START_CYC cycles have elapsed, and cpu_done=0 has been sampled (the CPU has left its IDLE).
  - On exit, cpu_start=0 and state goes to RUN.
  - If DONE_TIMEOUT cycles elapse without cpu_done=0, go to ERROR with cpu_start=0.
- RUN:
  - run=1, cpu_start=0, and a cycle counter increments.
  - abort=1 returns to IDLE and reasserts cpu_rst.
  - If RUN_LIMIT≠0 and the counter reaches RUN_LIMIT, return to IDLE and reassert cpu_rst.
  - If abort and the limit occur in the same cycle, abort wins; the result is identical.
  - cpu_done=1 in RUN (CPU returned to IDLE) returns to IDLE.
- ERROR:
  - err=1, cpu_rst=1, cpu_start=0, ld_ready=0.
  - err_clr=1 returns to IDLE and resets the pointer to BASE_ADDR.
  - ld_valid is ignored.
- Every entry to IDLE resets the pointer to BASE_ADDR.
- abort is ignored outside RUN. err_clr is ignored outside ERROR.
- mem_we is never asserted outside the cycle after an accepted byte.

Test Plan:
- After rst deasserts: cpu_rst=1, ld_ready=1, mem_we=0, cpu_start=0.
- Load bytes 0x11,0x22,0x33 (last on 0x33), BASE_ADDR=0:
  - writes addr0=0x11, addr1=0x22, addr2=0x33 on consecutive cycles.
  - then cpu_rst=0.
  - cpu_done held 1 gives cpu_start high for ≥2 cycles.
  - cpu_done drops to 0 after start rises; cpu_start falls; run=1.
- Bytes with ld_valid gaps (valid every other cycle): exactly one mem_we per accepted byte, addresses contiguous.
- RELEASE with cpu_done stuck 0 for 64 cycles: err=1, cpu_rst=1. err_clr then gives IDLE with ld_ready=1.
- Overflow, ADDR_W=2: 5 bytes without ld_last gives writes to addresses 0..3, err=1 after the 4th byte, and the 5th byte is not accepted.
- RUN_LIMIT=10: run=1 for exactly 10 cycles, then cpu_rst=1 and IDLE. Separately, abort in the 3rd RUN cycle ends RUN the next cycle.
